// File: rtl/arm_multicycle_ctrl.sv
// Multicycle ARM control unit: instruction sequencing FSM, ALU decode, NZCV flags, condition check.
// Optional ARM_MC_MEMREADY_EN: FETCH/MEMREAD/MEMWRITE wait for MemReady.
module arm_multicycle_ctrl (
    input  logic         clk,
    input  logic         reset,
    input  logic [31:12] Instr,
    input  logic [3:0]   ALUFlags,
    input  logic         MemReady,
    output logic         PCWrite,
    output logic         IRWrite,
    output logic         RegWrite,
    output logic         MemWrite,
    output logic         AdrSrc,
    output logic         ALUSrcA,
    output logic [1:0]   ALUSrcB,
    output logic [1:0]   ResultSrc,
    output logic [1:0]   RegSrc,
    output logic [1:0]   ImmSrc,
    output logic [1:0]   ALUControl,
    output logic         Carry,
    output logic [3:0]   State
);

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECUTER = 4'd6,
        EXECUTEI = 4'd7,
        ALUWB    = 4'd8,
        BRANCH   = 4'd9
    } state_e;

    state_e     state_q, state_d;
    logic [3:0] flags_q, flags_d;
    logic       condex_q, condex_d;

    logic [3:0] cond;
    logic [1:0] op;
    logic [5:0] funct;
    logic [3:0] cmd;
    logic [3:0] rd;
    logic       mem_rdy;
    logic       unused_bits;

    assign cond  = Instr[31:28];
    assign op    = Instr[27:26];
    assign funct = Instr[25:20];
    assign cmd   = funct[4:1];
    assign rd    = Instr[15:12];
    assign unused_bits = ^{Instr[19:16], MemReady};

`ifdef ARM_MC_MEMREADY_EN
    assign mem_rdy = MemReady;
`else
    assign mem_rdy = 1'b1;
`endif

    logic n_f, z_f, c_f, v_f, cond_pass;
    assign {n_f, z_f, c_f, v_f} = flags_q;

    always_comb begin
        cond_pass = 1'b0;
        case (cond)
            4'b0000: cond_pass = z_f;
            4'b0001: cond_pass = ~z_f;
            4'b0010: cond_pass = c_f;
            4'b0011: cond_pass = ~c_f;
            4'b0100: cond_pass = n_f;
            4'b0101: cond_pass = ~n_f;
            4'b0110: cond_pass = v_f;
            4'b0111: cond_pass = ~v_f;
            4'b1000: cond_pass = c_f & ~z_f;
            4'b1001: cond_pass = ~(c_f & ~z_f);
            4'b1010: cond_pass = (n_f == v_f);
            4'b1011: cond_pass = (n_f != v_f);
            4'b1100: cond_pass = ~z_f & (n_f == v_f);
            4'b1101: cond_pass = ~(~z_f & (n_f == v_f));
            4'b1110: cond_pass = 1'b1;
            default: cond_pass = 1'b0;
        endcase
    end

    logic [1:0] alu_ctl;
    logic       dp_wr, dp_arith;
    logic [1:0] flag_w;

    // Unrecognised commands fall back to ADD and never write the register file.
    always_comb begin
        alu_ctl  = 2'b00;
        dp_wr    = 1'b0;
        dp_arith = 1'b0;
        case (cmd)
            4'b0100: begin alu_ctl = 2'b00; dp_wr = 1'b1; dp_arith = 1'b1; end
            4'b0010: begin alu_ctl = 2'b01; dp_wr = 1'b1; dp_arith = 1'b1; end
            4'b0000: begin alu_ctl = 2'b10; dp_wr = 1'b1; end
            4'b1100: begin alu_ctl = 2'b11; dp_wr = 1'b1; end
            4'b1010: begin alu_ctl = 2'b01; dp_arith = 1'b1; end
            default: ;
        endcase
    end

    assign flag_w = {funct[0], funct[0] & dp_arith};

    logic regw, memw, branch, fetch_pc, ir_w;

    always_comb begin
        state_d    = state_q;
        regw       = 1'b0;
        memw       = 1'b0;
        branch     = 1'b0;
        fetch_pc   = 1'b0;
        ir_w       = 1'b0;
        AdrSrc     = 1'b0;
        ALUSrcA    = 1'b0;
        ALUSrcB    = 2'b00;
        ResultSrc  = 2'b00;
        ALUControl = 2'b00;
        case (state_q)
            FETCH: begin
                ALUSrcA   = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                ir_w      = mem_rdy;
                fetch_pc  = mem_rdy;
                if (mem_rdy) state_d = DECODE;
            end
            DECODE: begin
                ALUSrcA   = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                case (op)
                    2'b01:   state_d = MEMADR;
                    2'b00:   state_d = funct[5] ? EXECUTEI : EXECUTER;
                    2'b10:   state_d = BRANCH;
                    default: state_d = FETCH;
                endcase
            end
            MEMADR: begin
                ALUSrcB = 2'b01;
                state_d = funct[0] ? MEMREAD : MEMWRITE;
            end
            MEMREAD: begin
                AdrSrc = 1'b1;
                if (mem_rdy) state_d = MEMWB;
            end
            MEMWB: begin
                ResultSrc = 2'b01;
                regw      = 1'b1;
                state_d   = FETCH;
            end
            MEMWRITE: begin
                AdrSrc = 1'b1;
                memw   = 1'b1;
                if (mem_rdy) state_d = FETCH;
            end
            EXECUTER: begin
                ALUControl = alu_ctl;
                state_d    = ALUWB;
            end
            EXECUTEI: begin
                ALUSrcB    = 2'b01;
                ALUControl = alu_ctl;
                state_d    = ALUWB;
            end
            ALUWB: begin
                regw    = dp_wr;
                state_d = FETCH;
            end
            BRANCH: begin
                ALUSrcB   = 2'b01;
                ResultSrc = 2'b10;
                branch    = 1'b1;
                state_d   = FETCH;
            end
            default: state_d = FETCH;
        endcase
    end

    // CondEx is latched leaving DECODE so flag updates in EXECUTE cannot alter the running instruction.
    always_comb begin
        condex_d = (state_q == DECODE) ? cond_pass : condex_q;
        flags_d  = flags_q;
        if (((state_q == EXECUTER) || (state_q == EXECUTEI)) && condex_q) begin
            if (flag_w[1]) flags_d[3:2] = ALUFlags[3:2];
            if (flag_w[0]) flags_d[1:0] = ALUFlags[1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= FETCH;
            flags_q  <= '0;
            condex_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            flags_q  <= flags_d;
            condex_q <= condex_d;
        end
    end

    assign IRWrite  = reset & ir_w;
    assign RegWrite = reset & regw & condex_q;
    assign MemWrite = reset & memw & condex_q;
    assign PCWrite  = reset & (fetch_pc | (branch & condex_q) | (regw & condex_q & (rd == 4'd15)));

    assign ImmSrc = op;
    assign RegSrc = {op == 2'b01, op == 2'b10};
    assign Carry  = flags_q[1];
    assign State  = state_q;

endmodule

// File: tb/tb_arm_multicycle_ctrl.sv
// Self-checking bench for arm_multicycle_ctrl: instruction-level model compared every cycle,
// plus literal checks on flags, cycle counts and key write enables.
module tb_arm_multicycle_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [19:0] Instr;
    logic [3:0]  ALUFlags;
    logic        MemReady;
    logic        PCWrite, IRWrite, RegWrite, MemWrite, AdrSrc, ALUSrcA, Carry;
    logic [1:0]  ALUSrcB, ResultSrc, RegSrc, ImmSrc, ALUControl;
    logic [3:0]  State;

    always #5 clk = ~clk;

    arm_multicycle_ctrl dut (
        .clk(clk), .reset(reset), .Instr(Instr), .ALUFlags(ALUFlags), .MemReady(MemReady),
        .PCWrite(PCWrite), .IRWrite(IRWrite), .RegWrite(RegWrite), .MemWrite(MemWrite),
        .AdrSrc(AdrSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ResultSrc(ResultSrc),
        .RegSrc(RegSrc), .ImmSrc(ImmSrc), .ALUControl(ALUControl), .Carry(Carry), .State(State)
    );

`ifdef ARM_MC_MEMREADY_EN
    localparam bit STALLS = 1'b1;
`else
    localparam bit STALLS = 1'b0;
`endif

    typedef struct packed {
        logic pcw, irw, rw, mw, adr, srca;
        logic [1:0] srcb, res, regsrc, immsrc, aluc;
    } ctrl_t;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic        chk_en = 1'b0;
    ctrl_t       exp_c;
    logic [3:0]  exp_st;
    logic        exp_carry;
    logic [3:0]  m_flags;
    logic        m_condex;
    logic        pcw9, rw8, pcw8, wr_in_rst;
    logic [3:0]  ldr_wb;
    int          irw_cnt;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [19:0] mk(input logic [3:0] c, input logic [1:0] op,
                                       input logic [5:0] fn, input logic [3:0] rd);
        return {c, op, fn, 4'h0, rd};
    endfunction

    // Condition = base test on cond[3:1], inverted by cond[0]; 1110 always, 1111 never.
    function automatic logic cond_ok(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cc, v, base;
        {n, z, cc, v} = f;
        case (c[3:1])
            3'd0: base = z;
            3'd1: base = cc;
            3'd2: base = n;
            3'd3: base = v;
            3'd4: base = cc && !z;
            3'd5: base = (n == v);
            3'd6: base = !z && (n == v);
            default: base = 1'b1;
        endcase
        if (c == 4'hF) return 1'b0;
        return c[0] ? !base : base;
    endfunction

    function automatic logic [1:0] alu_code(input logic [3:0] cmd);
        case (cmd)
            4'b0010, 4'b1010: return 2'b01;
            4'b0000:          return 2'b10;
            4'b1100:          return 2'b11;
            default:          return 2'b00;
        endcase
    endfunction

    function automatic ctrl_t exp_ctrl(input logic [3:0] st, input logic [19:0] ins,
                                       input logic cx, input logic rdy, input logic rst);
        ctrl_t c;
        logic [1:0] op  = ins[15:14];
        logic [3:0] cmd = ins[12:9];
        logic       rd15 = (ins[3:0] == 4'd15);
        logic       dpw = (cmd == 4'b0100) || (cmd == 4'b0010) || (cmd == 4'b0000) || (cmd == 4'b1100);
        c = '0;
        c.immsrc = op;
        c.regsrc = {op == 2'b01, op == 2'b10};
        case (st)
            4'd0: begin c.srca = 1; c.srcb = 2'b10; c.res = 2'b10; c.irw = rdy; c.pcw = rdy; end
            4'd1: begin c.srca = 1; c.srcb = 2'b10; c.res = 2'b10; end
            4'd2: c.srcb = 2'b01;
            4'd3: c.adr = 1;
            4'd4: begin c.res = 2'b01; c.rw = cx; c.pcw = cx && rd15; end
            4'd5: begin c.adr = 1; c.mw = cx; end
            4'd6: c.aluc = alu_code(cmd);
            4'd7: begin c.srcb = 2'b01; c.aluc = alu_code(cmd); end
            4'd8: begin c.rw = cx && dpw; c.pcw = cx && dpw && rd15; end
            4'd9: begin c.srcb = 2'b01; c.res = 2'b10; c.pcw = cx; end
            default: ;
        endcase
        if (!rst) begin c.pcw = 0; c.irw = 0; c.rw = 0; c.mw = 0; end
        return c;
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            chk("State", 8'(State), 8'(exp_st));
            chk("PCWrite", 8'(PCWrite), 8'(exp_c.pcw));
            chk("IRWrite", 8'(IRWrite), 8'(exp_c.irw));
            chk("RegWrite", 8'(RegWrite), 8'(exp_c.rw));
            chk("MemWrite", 8'(MemWrite), 8'(exp_c.mw));
            chk("AdrSrc", 8'(AdrSrc), 8'(exp_c.adr));
            chk("ALUSrcA", 8'(ALUSrcA), 8'(exp_c.srca));
            chk("ALUSrcB", 8'(ALUSrcB), 8'(exp_c.srcb));
            chk("ResultSrc", 8'(ResultSrc), 8'(exp_c.res));
            chk("RegSrc", 8'(RegSrc), 8'(exp_c.regsrc));
            chk("ImmSrc", 8'(ImmSrc), 8'(exp_c.immsrc));
            chk("ALUControl", 8'(ALUControl), 8'(exp_c.aluc));
            chk("Carry", 8'(Carry), 8'(exp_carry));
            if (exp_st == 4'd9) pcw9 = PCWrite;
            if (exp_st == 4'd8) begin rw8 = RegWrite; pcw8 = PCWrite; end
            if (exp_st == 4'd4) ldr_wb = {ResultSrc, RegWrite, PCWrite};
            if (!reset) wr_in_rst = wr_in_rst | PCWrite | IRWrite | RegWrite | MemWrite;
            if (IRWrite) irw_cnt++;
        end
    end

    task automatic step(input logic [19:0] ins, input logic [3:0] alf, input logic rdy,
                        input logic rst, input logic [3:0] st);
        Instr = ins; ALUFlags = alf; MemReady = rdy; reset = rst;
        exp_st    = st;
        exp_c     = exp_ctrl(st, ins, m_condex, STALLS ? rdy : 1'b1, rst);
        exp_carry = m_flags[1];
        @(posedge clk);
        #1;
        if (!rst) begin
            m_flags = '0; m_condex = 1'b0;
        end else if (st == 4'd1) begin
            m_condex = cond_ok(ins[19:16], m_flags);
        end else if ((st == 4'd6 || st == 4'd7) && m_condex && ins[8]) begin
            m_flags[3:2] = alf[3:2];
            if (ins[12:9] == 4'b0100 || ins[12:9] == 4'b0010 || ins[12:9] == 4'b1010)
                m_flags[1:0] = alf[1:0];
        end
    endtask

    task automatic do_instr(input logic [19:0] ins, input logic [3:0] alf, input int stall,
                            input logic rdy_base, input int exp_cyc);
        int path[$];
        int idx = 0, cyc = 0, sl = stall;
        logic rdy;
        logic [3:0] st;
        case (ins[15:14])
            2'b01:   path = ins[8] ? '{0, 1, 2, 3, 4} : '{0, 1, 2, 5};
            2'b00:   path = ins[13] ? '{0, 1, 7, 8} : '{0, 1, 6, 8};
            2'b10:   path = '{0, 1, 9};
            default: path = '{0, 1};
        endcase
        while (idx < path.size()) begin
            st  = 4'(path[idx]);
            rdy = (st == 4'd0 && sl > 0) ? 1'b0 : rdy_base;
            if (st == 4'd0 && sl > 0) sl--;
            step(ins, alf, rdy, 1'b1, st);
            cyc++;
            if (!(STALLS && !rdy && (st == 4'd0 || st == 4'd3 || st == 4'd5))) idx++;
        end
        chk("cycles", 8'(cyc), 8'(exp_cyc));
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [19:0] ldr15;
        reset = 1'b0; Instr = '0; ALUFlags = '0; MemReady = 1'b1;
        m_flags = '0; m_condex = 1'b0;
        pcw9 = 0; rw8 = 0; pcw8 = 0; ldr_wb = '0; wr_in_rst = 0; irw_cnt = 0;
        @(posedge clk);
        #1;
        chk_en = 1'b1;
        step(mk(4'hE, 2'b00, 6'b001001, 4'd1), 4'b0000, 1'b1, 1'b0, 4'd0);
        chk("reset_nowrite", 8'(wr_in_rst), 8'd0);

        do_instr(mk(4'hE, 2'b00, 6'b001001, 4'd1), 4'b0100, 0, 1'b1, 4);
        chk("adds_rw8", 8'(rw8), 8'd1);
        chk("adds_flags", 8'(m_flags), 8'b0100);
        do_instr(mk(4'h0, 2'b10, 6'b100000, 4'd0), 4'b0000, 0, 1'b1, 3);
        chk("beq_taken", 8'(pcw9), 8'd1);
        do_instr(mk(4'hE, 2'b00, 6'b001001, 4'd1), 4'b0000, 0, 1'b1, 4);
        do_instr(mk(4'h0, 2'b10, 6'b100000, 4'd0), 4'b0000, 0, 1'b1, 3);
        chk("beq_not_taken", 8'(pcw9), 8'd0);

        ldr15 = mk(4'hE, 2'b01, 6'b011001, 4'd15);
        do_instr(ldr15, 4'b0000, 0, 1'b1, 5);
        chk("ldr_wb", 8'(ldr_wb), 8'b0111);
        do_instr(mk(4'hE, 2'b01, 6'b011000, 4'd3), 4'b0000, 0, 1'b1, 4);

        do_instr(mk(4'hE, 2'b00, 6'b010101, 4'd0), 4'b0110, 0, 1'b1, 4);
        chk("cmp_rw8", 8'(rw8), 8'd0);
        chk("cmp_flags", 8'(m_flags), 8'b0110);
        do_instr(mk(4'h1, 2'b00, 6'b101001, 4'd2), 4'b1001, 0, 1'b1, 4);
        chk("addne_rw8", 8'(rw8), 8'd0);
        chk("addne_flags", 8'(m_flags), 8'b0110);

        do_instr(mk(4'hE, 2'b00, 6'b000100, 4'd4), 4'b1111, 0, 1'b1, 4);
        do_instr(mk(4'hE, 2'b00, 6'b100000, 4'd5), 4'b1111, 0, 1'b1, 4);
        do_instr(mk(4'hE, 2'b00, 6'b011000, 4'd6), 4'b0000, 0, 1'b1, 4);
        do_instr(mk(4'hE, 2'b00, 6'b001000, 4'd15), 4'b0000, 0, 1'b1, 4);
        chk("add_pc_pcw8", 8'(pcw8), 8'd1);
        do_instr(mk(4'hE, 2'b00, 6'b000010, 4'd7), 4'b0000, 0, 1'b1, 4);
        chk("eor_rw8", 8'(rw8), 8'd0);
        do_instr(mk(4'hF, 2'b00, 6'b001000, 4'd8), 4'b0000, 0, 1'b1, 4);
        chk("never_rw8", 8'(rw8), 8'd0);
        do_instr(mk(4'hE, 2'b11, 6'b000000, 4'd0), 4'b0000, 0, 1'b1, 2);

`ifdef ARM_MC_MEMREADY_EN
        irw_cnt = 0;
        do_instr(mk(4'hE, 2'b00, 6'b001000, 4'd7), 4'b0000, 3, 1'b1, 7);
        chk("stall_irw_once", 8'(irw_cnt), 8'd1);
`else
        irw_cnt = 0;
        do_instr(mk(4'hE, 2'b00, 6'b001000, 4'd7), 4'b0000, 0, 1'b0, 4);
        chk("ignore_memready_irw", 8'(irw_cnt), 8'd1);
`endif

        // Abort an LDR in MEMREAD: reset is held for two edges, then execution restarts at FETCH.
        chk("carry_before_reset", 8'(m_flags[1]), 8'd1);
        step(ldr15, 4'b0000, 1'b1, 1'b1, 4'd0);
        step(ldr15, 4'b0000, 1'b1, 1'b1, 4'd1);
        step(ldr15, 4'b0000, 1'b1, 1'b1, 4'd2);
        wr_in_rst = 0;
        step(ldr15, 4'b0000, 1'b1, 1'b0, 4'd3);
        step(ldr15, 4'b0000, 1'b1, 1'b0, 4'd0);
        chk("midldr_reset_nowrite", 8'(wr_in_rst), 8'd0);
        chk("flags_after_reset", 8'(m_flags), 8'd0);
        do_instr(mk(4'h2, 2'b10, 6'b100000, 4'd0), 4'b0000, 0, 1'b1, 3);
        chk("bcs_after_reset", 8'(pcw9), 8'd0);
        do_instr(mk(4'hE, 2'b00, 6'b001001, 4'd1), 4'b0010, 0, 1'b1, 4);
        chk("adds_carry_flags", 8'(m_flags), 8'b0010);
        do_instr(mk(4'h2, 2'b10, 6'b100000, 4'd0), 4'b0000, 0, 1'b1, 3);
        chk("bcs_taken", 8'(pcw9), 8'd1);

        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
